// File: rtl/dcache_wb_reader.sv
// Writeback reader for the 4-way data-cache RAM: steps a victim line's word offsets,
// selects the captured way and streams the words to memory over a valid/ready port.
module dcache_wb_reader #(
  parameter int DW      = 32,
  parameter int INDEX_W = 7,
  parameter int WO_W    = 3,
  parameter int TAG_W   = 20
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wb_req,
  input  logic [TAG_W-1:0]                wb_tag,
  input  logic [INDEX_W-1:0]              wb_index,
  input  logic [1:0]                      wb_way,
  output logic                            wb_ack,
  output logic                            wb_busy,
  output logic                            wb_done,
  output logic [INDEX_W-1:0]              ram_index,
  output logic [WO_W-1:0]                 ram_offset,
  output logic                            ram_en,
  output logic                            ram_we,
  input  logic [DW-1:0]                   ram_dout0,
  input  logic [DW-1:0]                   ram_dout1,
  input  logic [DW-1:0]                   ram_dout2,
  input  logic [DW-1:0]                   ram_dout3,
  output logic                            mem_valid,
  input  logic                            mem_ready,
  output logic [TAG_W+INDEX_W+WO_W+1:0]   mem_addr,
  output logic [DW-1:0]                   mem_data,
  output logic                            mem_last
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [WO_W-1:0]    r_cnt, w_cnt_next;
  logic [TAG_W-1:0]   r_tag, w_tag_next;
  logic [INDEX_W-1:0] r_index, w_index_next;
  logic [1:0]         r_way, w_way_next;
  logic [DW-1:0]      r_mem_data, w_mem_data_next;
  logic [DW-1:0]      w_sel;
  logic               w_last;
  logic               w_hs;

  assign w_last = (r_cnt == {WO_W{1'b1}});
  assign w_hs   = (r_state == S_SEND) && mem_ready;

  // Way mux driven only by the captured way, never by the live request port.
  always_comb begin
    w_sel = ram_dout0;
    case (r_way)
      2'd0: w_sel = ram_dout0;
      2'd1: w_sel = ram_dout1;
      2'd2: w_sel = ram_dout2;
      2'd3: w_sel = ram_dout3;
      default: w_sel = ram_dout0;
    endcase
  end

  // Look one word ahead on a non-final handshake so the next word is ready with no bubble.
  always_comb begin
    ram_offset = r_cnt;
    if (w_hs && !w_last) ram_offset = r_cnt + 1'b1;
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_tag_next      = r_tag;
    w_index_next    = r_index;
    w_way_next      = r_way;
    w_mem_data_next = r_mem_data;
    case (r_state)
      S_IDLE: begin
        if (wb_req) begin
          w_tag_next   = wb_tag;
          w_index_next = wb_index;
          w_way_next   = wb_way;
          w_cnt_next   = '0;
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_mem_data_next = w_sel;
        w_state_next    = S_SEND;
      end
      S_SEND: begin
        if (mem_ready) begin
          if (w_last) begin
            w_state_next = S_DONE;
          end else begin
            w_mem_data_next = w_sel;
            w_cnt_next      = r_cnt + 1'b1;
          end
        end
      end
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_tag      <= '0;
      r_index    <= '0;
      r_way      <= '0;
      r_mem_data <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_tag      <= w_tag_next;
      r_index    <= w_index_next;
      r_way      <= w_way_next;
      r_mem_data <= w_mem_data_next;
    end
  end

  assign wb_ack    = (r_state == S_IDLE) && wb_req && !rst;
  assign wb_busy   = (r_state != S_IDLE);
  assign wb_done   = (r_state == S_DONE);
  assign ram_index = r_index;
  assign ram_en    = (r_state != S_IDLE);
  assign ram_we    = 1'b0;
  assign mem_valid = (r_state == S_SEND);
  assign mem_addr  = {r_tag, r_index, r_cnt, 2'b00};
  assign mem_data  = r_mem_data;
  assign mem_last  = (r_state == S_SEND) && w_last;

endmodule

// File: tb/tb_dcache_wb_reader.sv
// Scoreboard bench for dcache_wb_reader: requests push expected words, a negedge
// monitor pops and compares every word the DUT presents.
module tb_dcache_wb_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_req;
  logic [19:0] wb_tag;
  logic [6:0]  wb_index;
  logic [1:0]  wb_way;
  logic        wb_ack, wb_busy, wb_done;
  logic [6:0]  ram_index;
  logic [2:0]  ram_offset;
  logic        ram_en, ram_we;
  logic [31:0] ram_dout0, ram_dout1, ram_dout2, ram_dout3;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_data;
  logic        mem_last;

  dcache_wb_reader dut (
    .clk(clk), .rst(rst), .wb_req(wb_req), .wb_tag(wb_tag), .wb_index(wb_index),
    .wb_way(wb_way), .wb_ack(wb_ack), .wb_busy(wb_busy), .wb_done(wb_done),
    .ram_index(ram_index), .ram_offset(ram_offset), .ram_en(ram_en), .ram_we(ram_we),
    .ram_dout0(ram_dout0), .ram_dout1(ram_dout1), .ram_dout2(ram_dout2), .ram_dout3(ram_dout3),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_last(mem_last)
  );

  always #5 clk = ~clk;

  // RAM model: word value encodes way, set and offset so every word is distinct.
  logic [31:0] ram_m [4][1024];
  assign ram_dout0 = ram_m[0][{ram_index, ram_offset}];
  assign ram_dout1 = ram_m[1][{ram_index, ram_offset}];
  assign ram_dout2 = ram_m[2][{ram_index, ram_offset}];
  assign ram_dout3 = ram_m[3][{ram_index, ram_offset}];

  function automatic logic [31:0] pat(input int w, input int i, input int o);
    return 32'h1000_0000 * (w + 1) + (i << 8) + o;
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int ack_count = 0, done_count = 0, hs_count = 0;
  int ack_cyc = 0, done_cyc = 0, valid_rise_cyc = 0;
  int hs_base = 0, done_base = 0;
  bit rdy_toggle = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_line(input logic [19:0] tag, input logic [6:0] idx, input logic [1:0] way);
    exp_t e;
    logic [2:0] off;
    for (int o = 0; o < 8; o++) begin
      off    = o[2:0];
      e.addr = {tag, idx, off, 2'b00};
      e.data = pat(int'(way), int'(idx), o);
      e.last = (o == 7);
      exp_q.push_back(e);
    end
  endtask

  // Called at a posedge time; returns at accept-edge + 1.
  task automatic start_req(input logic [19:0] tag, input logic [6:0] idx, input logic [1:0] way,
                           input bit hold);
    int a0;
    bit got;
    a0 = ack_count;
    got = 0;
    done_base = done_count;
    #1;
    wb_req = 1'b1; wb_tag = tag; wb_index = idx; wb_way = way;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk);
      if (ack_count != a0) got = 1;
    end
    chk("ack_seen", 32'(got), 32'd1);
    #1;
    if (!hold) wb_req = 1'b0;
    push_line(tag, idx, way);
    hs_base = hs_count;
  endtask

  task automatic wait_done(input logic [19:0] tag, input logic [6:0] idx, input logic [1:0] way);
    bit got;
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk);
      if (done_count != done_base) got = 1;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("words_per_line", 32'(hs_count - hs_base), 32'd8);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("xfer tag=0x%05h idx=%0d way=%0d words=%0d done_cyc=%0d", tag, idx, way,
             hs_count - hs_base, done_cyc);
  endtask

  // Monitor: counts pulses and scoreboards every presented word.
  initial begin
    bit   prev_valid;
    exp_t e;
    prev_valid = 0;
    forever begin
      @(negedge clk);
      if (wb_ack)  begin ack_count++;  ack_cyc  = cyc; end
      if (wb_done) begin done_count++; done_cyc = cyc; end
      if (mem_valid) begin
        if (!prev_valid) valid_rise_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got addr 0x%08h data 0x%08h expected no word", mem_addr, mem_data);
        end else begin
          e = exp_q[0];
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_data", mem_data, e.data);
          chk("mem_last", 32'(mem_last), 32'(e.last));
          if (mem_ready) void'(exp_q.pop_front());
        end
        if (mem_ready) hs_count++;
        chk("ram_we", 32'(ram_we), 32'd0);
      end
      prev_valid = mem_valid;
    end
  end

  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_toggle) mem_ready = ~mem_ready;
      else            mem_ready = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  a_before, d_before;
    bit  got;
    for (int w = 0; w < 4; w++)
      for (int a = 0; a < 1024; a++)
        ram_m[w][a] = pat(w, a >> 3, a & 7);
    rst = 1'b1; wb_req = 1'b0; wb_tag = '0; wb_index = '0; wb_way = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_busy",  32'(wb_busy),   32'd0);
    chk("rst_done",  32'(wb_done),   32'd0);
    chk("rst_ack",   32'(wb_ack),    32'd0);
    chk("rst_data",  mem_data,       32'd0);
    chk("rst_ram_en", 32'(ram_en),   32'd0);
    @(posedge clk);

    // 1: full line, ready always high
    start_req(20'hABCDE, 7'd5, 2'd2, 0);
    @(negedge clk);
    chk("load_valid", 32'(mem_valid), 32'd0);
    chk("load_busy",  32'(wb_busy),   32'd1);
    chk("load_ram_en", 32'(ram_en),   32'd1);
    @(negedge clk);
    chk("first_valid", 32'(mem_valid), 32'd1);
    chk("first_addr",  mem_addr, 32'hABCDE0A0);
    chk("first_data",  mem_data, 32'h30000500);
    wait_done(20'hABCDE, 7'd5, 2'd2);
    chk("valid_latency", 32'(valid_rise_cyc - ack_cyc), 32'd2);
    chk("done_latency",  32'(done_cyc - ack_cyc), 32'd10);

    // 2: ready toggling
    rdy_toggle = 1;
    start_req(20'hABCDE, 7'd5, 2'd2, 0);
    wait_done(20'hABCDE, 7'd5, 2'd2);
    rdy_toggle = 0;

    // 3: request held high across the transfer
    a_before = ack_count;
    start_req(20'h0F00D, 7'd33, 2'd1, 1);
    wait_done(20'h0F00D, 7'd33, 2'd1);
    chk("single_ack", 32'(ack_count - a_before), 32'd1);
    start_req(20'h0F00D, 7'd33, 2'd1, 0);
    chk("reaccept_gap", 32'(ack_cyc - done_cyc), 32'd1);
    wait_done(20'h0F00D, 7'd33, 2'd1);
    chk("two_acks", 32'(ack_count - a_before), 32'd2);

    // 4: request inputs change mid-transfer
    start_req(20'h55AA5, 7'd64, 2'd3, 0);
    repeat (3) @(posedge clk);
    #1 wb_way = 2'd1; wb_index = 7'd9; wb_tag = 20'h11111;
    wait_done(20'h55AA5, 7'd64, 2'd3);

    // 5: reset at word 3
    start_req(20'h13579, 7'd77, 2'd1, 0);
    d_before = done_count;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(posedge clk);
      if (hs_count - hs_base >= 3) got = 1;
    end
    chk("reach_word3", 32'(got), 32'd1);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_mid_valid", 32'(mem_valid), 32'd0);
    chk("rst_mid_busy",  32'(wb_busy),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    chk("no_done_on_rst", 32'(done_count), 32'(d_before));
    start_req(20'h24680, 7'd77, 2'd0, 0);
    wait_done(20'h24680, 7'd77, 2'd0);

    // 6: every way
    for (int w = 0; w < 4; w++) begin
      start_req(20'h12340 + 20'(w), 7'(100 + w), 2'(w), 0);
      wait_done(20'h12340 + 20'(w), 7'(100 + w), 2'(w));
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
